// File: rtl/random_stimulus_bank_pkg.sv
// Shared constants, mode encoding and per-lane seed derivation for the
// random stimulus bank.
package random_gen_pkg;

  localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
  localparam logic [31:0] SEED_STRIDE = 32'h9E37_79B9;

  typedef enum logic [1:0] {
    MODE_LFSR  = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_HOLD  = 2'b10,
    MODE_STEP  = 2'b11
  } mode_e;

  // Lanes are decorrelated by a golden-ratio stride; zero would lock the LFSR.
  function automatic logic [31:0] lane_seed(input logic [31:0] base, input logic [31:0] idx);
    logic [31:0] w_mix;
    w_mix = base ^ (idx * SEED_STRIDE);
    return (w_mix == 32'h0) ? 32'h1 : w_mix;
  endfunction

endpackage

// File: rtl/random_stimulus_bank_if.sv
// Control/data bundle between a stimulus consumer (master) and the bank (slave).
interface random_stimulus_bank_if #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned WIDTH        = 32
);

  logic                          enable;
  logic [1:0]                    mode;
  logic                          step;
  logic                          seed_load;
  logic [31:0]                   seed_in;
  logic [NUM_CHANNELS*WIDTH-1:0] random_number;
  logic                          update_strobe;

  modport master (
    output enable, mode, step, seed_load, seed_in,
    input  random_number, update_strobe
  );

  modport slave (
    input  enable, mode, step, seed_load, seed_in,
    output random_number, update_strobe
  );

endinterface

// File: rtl/random_stimulus_bank_lane.sv
// One 32-bit lane: seed load, Galois LFSR or counter advance, else hold.
module rng_lane
  import random_gen_pkg::*;
#(
  parameter int unsigned IDX  = 0,
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_load_base,
  input  logic        i_advance,
  input  logic        i_use_count,
  output logic [31:0] o_state
);

  logic [31:0] r_state;
  logic [31:0] w_next;

  // Next-state selection; load outranks advance.
  always_comb begin
    w_next = r_state;
    if (i_load) begin
      w_next = lane_seed(i_load_base, 32'(IDX));
    end else if (i_advance) begin
      if (i_use_count) begin
        w_next = r_state + 32'd1;
      end else if (r_state == 32'h0) begin
        w_next = 32'h0000_0001;
      end else begin
        w_next = (r_state >> 1) ^ (r_state[0] ? LFSR_MASK : 32'h0);
      end
    end else begin
      w_next = r_state;
    end
  end

  // Lane state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= lane_seed(SEED, 32'(IDX));
    end else begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/random_stimulus_bank.sv
// N-lane pseudo-random source: shared rate divider, advance decode, update
// strobe and packing of the lane states onto one wide output bus.
module random_stimulus_bank
  import random_gen_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] SEED         = 32'h0000_0001,
  parameter int unsigned RATE_DIV     = 1
) (
  input logic                    clk,
  input logic                    reset,
  random_stimulus_bank_if.slave  bus
);

  localparam int unsigned     DIV_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);

  mode_e                         w_mode;
  logic [DIV_W-1:0]              r_div;
  logic                          r_strobe;
  logic                          w_tick;
  logic                          w_advance;
  logic                          w_use_count;
  logic [31:0]                   w_state [NUM_CHANNELS];
  logic [NUM_CHANNELS*WIDTH-1:0] w_rn;

  assign w_mode = mode_e'(bus.mode);

  // Advance decode; a seed load swallows any coincident tick or step.
  always_comb begin
    w_tick      = bus.enable && (r_div == DIV_LAST);
    w_advance   = 1'b0;
    w_use_count = 1'b0;
    if (bus.seed_load) begin
      w_advance = 1'b0;
    end else begin
      case (w_mode)
        MODE_LFSR:  w_advance = w_tick;
        MODE_COUNT: begin
          w_advance   = w_tick;
          w_use_count = 1'b1;
        end
        MODE_HOLD:  w_advance = 1'b0;
        MODE_STEP:  w_advance = bus.step;
        default:    w_advance = 1'b0;
      endcase
    end
  end

  // Rate divider: counts enabled cycles in every mode, frozen when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (bus.seed_load) begin
      r_div <= '0;
    end else if (bus.enable) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end else begin
      r_div <= r_div;
    end
  end

  // Strobe marks the cycle in which the freshly advanced value is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_advance;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
    rng_lane #(
      .IDX  (g),
      .SEED (SEED)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .i_load      (bus.seed_load),
      .i_load_base (bus.seed_in),
      .i_advance   (w_advance),
      .i_use_count (w_use_count),
      .o_state     (w_state[g])
    );
  end

  // Output packing: low WIDTH bits of each lane, lane 0 in the LSBs.
  always_comb begin
    w_rn = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_rn[i*WIDTH +: WIDTH] = w_state[i][WIDTH-1:0];
    end
  end

  assign bus.random_number = w_rn;
  assign bus.update_strobe = r_strobe;

endmodule

// File: tb/tb_random_stimulus_bank.sv
// Two bank configurations checked every cycle against a behavioural model,
// plus directed scenarios with hand-computed constants.
module tb_random_stimulus_bank;

  localparam int NA = 2;
  localparam int WA = 32;
  localparam int RA = 1;
  localparam logic [31:0] SA = 32'h0000_0001;
  localparam int NB = 3;
  localparam int WB = 16;
  localparam int RB = 4;
  localparam logic [31:0] SB = 32'hCAFE_1234;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  random_stimulus_bank_if #(.NUM_CHANNELS(NA), .WIDTH(WA)) ifa ();
  random_stimulus_bank_if #(.NUM_CHANNELS(NB), .WIDTH(WB)) ifb ();

  random_stimulus_bank #(.NUM_CHANNELS(NA), .WIDTH(WA), .SEED(SA), .RATE_DIV(RA)) u_dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  random_stimulus_bank #(.NUM_CHANNELS(NB), .WIDTH(WB), .SEED(SB), .RATE_DIV(RB)) u_dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Model: lane states, enabled-cycle count since last load/reset, strobe.
  logic [31:0] m_st [2][4];
  int          m_cnt [2];
  logic        m_strobe [2];

  function automatic logic [31:0] ref_seed(input logic [31:0] base, input int i);
    logic [31:0] s;
    s = base ^ (32'(i) * 32'h9E37_79B9);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    if (s == 32'h0) return 32'h1;
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic model_edge(input int d, input int nch, input int rate, input logic [31:0] base,
                            input logic en, input logic [1:0] md, input logic st,
                            input logic ld, input logic [31:0] sin);
    bit tick;
    bit adv;
    if (reset) begin
      for (int i = 0; i < nch; i++) m_st[d][i] = ref_seed(base, i);
      m_cnt[d] = 0;
      m_strobe[d] = 1'b0;
    end else if (ld) begin
      for (int i = 0; i < nch; i++) m_st[d][i] = ref_seed(sin, i);
      m_cnt[d] = 0;
      m_strobe[d] = 1'b0;
    end else begin
      tick = en && ((m_cnt[d] % rate) == rate - 1);
      if (en) m_cnt[d]++;
      adv = ((md == 2'd0 || md == 2'd1) && tick) || (md == 2'd3 && st);
      if (adv) begin
        for (int i = 0; i < nch; i++)
          m_st[d][i] = (md == 2'd1) ? m_st[d][i] + 32'd1 : lfsr_next(m_st[d][i]);
      end
      m_strobe[d] = adv;
    end
  endtask

  function automatic logic [63:0] exp_rn(input int d, input int nch, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nch; i++)
      for (int b = 0; b < w; b++) r[i*w + b] = m_st[d][i][b];
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge(0, NA, RA, SA, ifa.enable, ifa.mode, ifa.step, ifa.seed_load, ifa.seed_in);
    model_edge(1, NB, RB, SB, ifb.enable, ifb.mode, ifb.step, ifb.seed_load, ifb.seed_in);
    #1;
    check_eq("rn_a", 64'(ifa.random_number), exp_rn(0, NA, WA));
    check_eq("strobe_a", 64'(ifa.update_strobe), 64'(m_strobe[0]));
    check_eq("rn_b", 64'(ifb.random_number), exp_rn(1, NB, WB));
    check_eq("strobe_b", 64'(ifb.update_strobe), 64'(m_strobe[1]));
  endtask

  int          n_strobe;
  int          n_change;
  logic [63:0] prev_rn;
  bit          en_pat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    reset = 1'b1;
    ifa.enable = 1'b0; ifa.mode = 2'd0; ifa.step = 1'b0; ifa.seed_load = 1'b0; ifa.seed_in = 32'h0;
    ifb.enable = 1'b0; ifb.mode = 2'd0; ifb.step = 1'b0; ifb.seed_load = 1'b0; ifb.seed_in = 32'h0;
    cycle();
    cycle();
    reset = 1'b0;
    check_eq("rst_a_lane0", 64'(ifa.random_number[31:0]), 64'h0000_0001);
    check_eq("rst_a_lane1", 64'(ifa.random_number[63:32]), 64'h9E37_79B8);
    check_eq("rst_a_strobe", 64'(ifa.update_strobe), 64'h0);

    // Free-running LFSR at full rate.
    ifa.mode = 2'd0; ifa.enable = 1'b1;
    cycle();
    check_eq("lfsr1_lane0", 64'(ifa.random_number[31:0]), 64'h8020_0003);
    check_eq("lfsr1_strobe", 64'(ifa.update_strobe), 64'h1);
    cycle();
    check_eq("lfsr2_lane0", 64'(ifa.random_number[31:0]), 64'hC030_0002);
    check_eq("lfsr2_strobe", 64'(ifa.update_strobe), 64'h1);
    ifa.enable = 1'b0;

    // Divide-by-4 with a gap in enable.
    ifb.seed_load = 1'b1; ifb.seed_in = SB;
    cycle();
    ifb.seed_load = 1'b0; ifb.mode = 2'd0;
    n_strobe = 0; n_change = 0; prev_rn = 64'(ifb.random_number);
    for (int k = 0; k < 8; k++) begin
      ifb.enable = (k < 5) ? en_pat[k] : 1'b0;
      cycle();
      if (ifb.update_strobe) n_strobe++;
      if (64'(ifb.random_number) != prev_rn) n_change++;
      prev_rn = 64'(ifb.random_number);
      if (k == 3) check_eq("div_no_early", 64'(ifb.update_strobe), 64'h0);
    end
    check_eq("div_strobes", 64'(n_strobe), 64'd1);
    check_eq("div_changes", 64'(n_change), 64'd1);

    // Seed load coincident with a tick wins and suppresses the strobe.
    ifa.mode = 2'd0; ifa.enable = 1'b1; ifa.seed_load = 1'b1; ifa.seed_in = 32'h0;
    cycle();
    check_eq("load_lane0", 64'(ifa.random_number[31:0]), 64'h0000_0001);
    check_eq("load_lane1", 64'(ifa.random_number[63:32]), 64'h9E37_79B9);
    check_eq("load_strobe", 64'(ifa.update_strobe), 64'h0);

    // Counter wrap, then lockup guard on return to LFSR.
    ifa.seed_in = 32'hFFFF_FFFE;
    cycle();
    ifa.seed_load = 1'b0; ifa.mode = 2'd1;
    cycle();
    check_eq("cnt_ffffffff", 64'(ifa.random_number[31:0]), 64'hFFFF_FFFF);
    cycle();
    check_eq("cnt_wrap0", 64'(ifa.random_number[31:0]), 64'h0);
    ifa.mode = 2'd0;
    cycle();
    check_eq("lockup_guard", 64'(ifa.random_number[31:0]), 64'h0000_0001);
    ifa.enable = 1'b0;

    // Step mode ignores enable: three isolated pulses, three advances.
    ifa.mode = 2'd3;
    n_strobe = 0;
    for (int k = 0; k < 6; k++) begin
      ifa.step = (k % 2 == 0);
      cycle();
      if (ifa.update_strobe) n_strobe++;
    end
    ifa.step = 1'b0;
    check_eq("step_strobes", 64'(n_strobe), 64'd3);
    check_eq("step_lane0", 64'(ifa.random_number[31:0]), 64'h6018_0001);

    // Hold mode: divider runs, value and strobe stay quiet.
    ifb.mode = 2'd2; ifb.enable = 1'b1;
    prev_rn = 64'(ifb.random_number);
    n_strobe = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (ifb.update_strobe) n_strobe++;
    end
    check_eq("hold_value", 64'(ifb.random_number), prev_rn);
    check_eq("hold_strobes", 64'(n_strobe), 64'd0);

    // Randomized soak on both configurations.
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      ifa.enable = 1'($urandom_range(0, 1)); ifa.mode = 2'($urandom_range(0, 3));
      ifa.step = 1'($urandom_range(0, 1)); ifa.seed_load = ($urandom_range(0, 19) == 0);
      ifa.seed_in = $urandom;
      ifb.enable = 1'($urandom_range(0, 1)); ifb.mode = 2'($urandom_range(0, 3));
      ifb.step = 1'($urandom_range(0, 1)); ifb.seed_load = ($urandom_range(0, 19) == 0);
      ifb.seed_in = $urandom;
      cycle();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/random_stimulus_bank.md
# random_stimulus_bank

Parametrised multi-channel pseudo-random stimulus source for out-of-context builds. It drives otherwise-unconnected wide input buses of a design-under-build so synthesis cannot prune the logic behind them. It generalises the single 32-bit generator to N independent lanes of configurable width. It adds update-rate division, runtime reseeding, counter/hold/step modes and an update strobe.

## Interface
- NUM_CHANNELS, 4, number of independent lanes (1..16)
- WIDTH, 32, bits per lane taken from the lane state (1..32)
- SEED, 32'h0000_0001, base seed; lane i reset seed = SEED ^ (i * 32'h9E37_79B9), replaced by 32'h1 if result is zero
- RATE_DIV, 1, lanes advance once every RATE_DIV enabled cycles (>=1)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  gates the rate divider
- mode  in  2  00 LFSR, 01 counter, 10 hold, 11 step
- step  in  1  single-cycle advance request, used only in step mode
- seed_load  in  1  load seed_in into all lanes, derived per lane as for SEED
- seed_in  in  32  runtime base seed
- random_number  out  NUM_CHANNELS*WIDTH  lane i drives bits [i*WIDTH +: WIDTH] = low WIDTH bits of lane state
- update_strobe  out  1  high for one cycle when random_number has just changed due to an advance

## Operation
- Each lane holds a 32-bit state register. random_number is a direct slice of state, with no extra register.
- Advance, LFSR mode: Galois right shift. lsb = s[0]; s = s >> 1; if lsb, s ^= 32'h8020_0003.
- Advance, counter mode: s = s + 1 mod 2^32. The state wraps from FFFF_FFFF to 0, and zero is legal here.
- Lockup guard: in LFSR mode a zero state is replaced by 32'h1 instead of shifting.
- Hold mode: there are no advances. The divider keeps counting but ticks are discarded, and no strobe is issued.
- Step mode: advance once per cycle with step=1, using the LFSR rule. This ignores enable and the divider.
- Tick (modes 00/01): div counter counts enabled cycles from 0 to RATE_DIV-1. A tick occurs in the cycle div==RATE_DIV-1 with enable=1. div then returns to 0. With RATE_DIV=1, every enabled cycle is a tick.
- enable=0 freezes div. It does not clear it.
- Priority, highest first: reset, seed_load, advance. When seed_load is high:
  - all lanes take their derived seeds;
  - div is cleared;
  - any coincident tick or step is discarded, and no strobe is issued.
- mode is sampled every cycle. A change affects the next advance only and never alters state directly.

## Timing
- Reset, after the first edge with reset=1:
  - state = derived SEED per lane;
  - div = 0;
  - update_strobe = 0;
  - random_number = low WIDTH bits of the derived seeds.
- Advance latency: the state changes on the edge that ends the tick/step cycle. update_strobe is high in the following cycle, coincident with the new value.
- Back-to-back advances give a continuously high strobe.
- Seed load: the new value is visible in the cycle after seed_load is high. The first tick then occurs RATE_DIV enabled cycles later.
- Reset mid-count discards div and state unconditionally.

## Structure
- Package random_gen_pkg holds:
  - LFSR_MASK = 32'h8020_0003;
  - SEED_STRIDE = 32'h9E37_79B9;
  - mode enum (MODE_LFSR, MODE_COUNT, MODE_HOLD, MODE_STEP);
  - function lane_seed(base, idx) with the zero-to-one fix.
- Sub-module rng_lane: one 32-bit state register with its advance/load logic. It is instantiated NUM_CHANNELS times by a generate loop.
- The top level owns the divider, the strobe register and the output packing.

## Test plan
- Reset with SEED=1, NUM_CHANNELS=2, WIDTH=32 -> lane0=0000_0001 and lane1=9E37_79B8; update_strobe=0.
- RATE_DIV=1, mode=00, enable=1, SEED=1 -> lane0 goes 8020_0003, then C030_0002 on consecutive cycles, with update_strobe high from the first advance.
- RATE_DIV=4, enable toggled 1,1,0,1,1 -> exactly one advance, after the 4th enabled cycle. The strobe is high for exactly one cycle.
- seed_load=1, seed_in=0, asserted in the same cycle as a tick -> lane0=0000_0001 and lane1=9E37_79B9. No advance and no strobe occur.
- Mode 01 from lane0=FFFF_FFFE -> two ticks give FFFF_FFFF then 0000_0000. Switching to mode 00 then gives 0000_0001 on the next tick.
- Mode 11 with step pulses on 3 non-consecutive cycles and enable=0 -> exactly 3 LFSR advances. Mode 10 with enable=1 for 20 cycles -> random_number constant and update_strobe never high.
